nn_linear_sequencer: RTL and testbench

//  Sequences one fully-connected layer y = W*x + b on a single shared MAC, one output at a time.

---
 rtl/nn_linear_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_nn_linear_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nn_linear_sequencer.sv
// One fully-connected layer y = W*x + b evaluated on a single shared MAC,
// one output row at a time, against synchronous parameter/activation memories.
module nn_linear_sequencer #(
  parameter int IN_FEATURES  = 3,
  parameter int OUT_FEATURES = 2,
  parameter int DATA_W       = 16,
  parameter int FRAC_BITS    = 8,
  localparam int W_AW = (IN_FEATURES * OUT_FEATURES > 1) ? $clog2(IN_FEATURES * OUT_FEATURES) : 1,
  localparam int X_AW = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1,
  localparam int Y_AW = (OUT_FEATURES > 1) ? $clog2(OUT_FEATURES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [W_AW-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [X_AW-1:0]   x_addr,
  input  logic [DATA_W-1:0] x_data,
  output logic [Y_AW-1:0]   b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [Y_AW-1:0]   y_addr,
  output logic [DATA_W-1:0] y_data,
  output logic              y_we
);

  localparam int P_W   = 2 * DATA_W;
  localparam int ACC_W = P_W + X_AW + 1;
  localparam int SUM_W = ACC_W + 1;

  localparam logic [X_AW-1:0] X_LAST = X_AW'(IN_FEATURES - 1);
  localparam logic [Y_AW-1:0] B_LAST = Y_AW'(OUT_FEATURES - 1);
  localparam logic signed [SUM_W-1:0] Y_MAX = {{(SUM_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Drop the fractional bits (arithmetic shift, floor) and clamp to the word range.
  function automatic logic [DATA_W-1:0] sat_fn(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] s;
    s = v >>> FRAC_BITS;
    if (s > Y_MAX) begin
      sat_fn = Y_MAX[DATA_W-1:0];
    end else if (s < Y_MIN) begin
      sat_fn = Y_MIN[DATA_W-1:0];
    end else begin
      sat_fn = s[DATA_W-1:0];
    end
  endfunction

  state_t state_q, state_d;
  logic [W_AW-1:0]         w_addr_q, w_addr_d;
  logic [X_AW-1:0]         x_addr_q, x_addr_d;
  logic [Y_AW-1:0]         b_addr_q, b_addr_d;
  logic [Y_AW-1:0]         y_addr_q, y_addr_d;
  logic [DATA_W-1:0]       y_data_q, y_data_d;
  logic                    y_we_q, y_we_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic signed [P_W-1:0]   w_ext_s, x_ext_s, prod_s;
  logic signed [ACC_W-1:0] acc_add_s;
  logic signed [SUM_W-1:0] bias_s;

  assign w_ext_s = P_W'($signed(w_data));
  assign x_ext_s = P_W'($signed(x_data));
  assign prod_s  = w_ext_s * x_ext_s;
  assign bias_s  = SUM_W'($signed(b_data)) <<< FRAC_BITS;

  // Next-state, counters (x_addr is the column index, b_addr the row index) and output decode.
  always_comb begin
    state_d   = state_q;
    w_addr_d  = w_addr_q;
    x_addr_d  = x_addr_q;
    b_addr_d  = b_addr_q;
    y_addr_d  = y_addr_q;
    y_data_d  = y_data_q;
    acc_d     = acc_q;
    valid_d   = 1'b0;
    acc_add_s = valid_q ? (acc_q + ACC_W'(prod_s)) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_MAC;
          w_addr_d = '0;
          x_addr_d = '0;
          b_addr_d = '0;
          acc_d    = '0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_MAC: begin
        valid_d = 1'b1;
        acc_d   = acc_add_s;
        if (x_addr_q == X_LAST) begin
          state_d  = S_DRAIN;
        end else begin
          x_addr_d = x_addr_q + X_AW'(1);
          w_addr_d = w_addr_q + W_AW'(1);
        end
      end
      S_DRAIN: begin
        // Bias has been valid since the second MAC cycle; fold it in with the last product.
        acc_d    = acc_add_s;
        y_addr_d = b_addr_q;
        y_data_d = sat_fn(SUM_W'(acc_add_s) + bias_s);
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        acc_d = '0;
        if (b_addr_q == B_LAST) begin
          state_d  = S_DONE;
        end else begin
          state_d  = S_MAC;
          b_addr_d = b_addr_q + Y_AW'(1);
          x_addr_d = '0;
          w_addr_d = w_addr_q + W_AW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_MAC) || (state_d == S_DRAIN) || (state_d == S_WRITE);
    y_we_d = (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset is synchronous and active-high.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      w_addr_q <= '0;
      x_addr_q <= '0;
      b_addr_q <= '0;
      y_addr_q <= '0;
      y_data_q <= '0;
      y_we_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      w_addr_q <= w_addr_d;
      x_addr_q <= x_addr_d;
      b_addr_q <= b_addr_d;
      y_addr_q <= y_addr_d;
      y_data_q <= y_data_d;
      y_we_q   <= y_we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign w_addr = w_addr_q;
  assign x_addr = x_addr_q;
  assign b_addr = b_addr_q;
  assign y_addr = y_addr_q;
  assign y_data = y_data_q;
  assign y_we   = y_we_q;

endmodule

// File: tb/tb_nn_linear_sequencer.sv
// Directed bench: a 3x2 instance and a 1x4 instance, each fed from synchronous memory models.
module tb_nn_linear_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b;

  logic        busy_a, done_a, y_we_a;
  logic [2:0]  w_addr_a;
  logic [1:0]  x_addr_a;
  logic [0:0]  b_addr_a, y_addr_a;
  logic [15:0] w_data_a, x_data_a, b_data_a, y_data_a;

  logic        busy_b, done_b, y_we_b;
  logic [1:0]  w_addr_b;
  logic [0:0]  x_addr_b;
  logic [1:0]  b_addr_b, y_addr_b;
  logic [15:0] w_data_b, x_data_b, b_data_b, y_data_b;

  logic [15:0] wm_a [0:7];
  logic [15:0] xm_a [0:3];
  logic [15:0] bm_a [0:1];
  logic [15:0] wm_b [0:3];
  logic [15:0] xm_b [0:1];
  logic [15:0] bm_b [0:3];

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  nn_linear_sequencer #(.IN_FEATURES(3), .OUT_FEATURES(2), .DATA_W(16), .FRAC_BITS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .w_addr(w_addr_a), .w_data(w_data_a), .x_addr(x_addr_a), .x_data(x_data_a),
    .b_addr(b_addr_a), .b_data(b_data_a), .y_addr(y_addr_a), .y_data(y_data_a), .y_we(y_we_a)
  );

  nn_linear_sequencer #(.IN_FEATURES(1), .OUT_FEATURES(4), .DATA_W(16), .FRAC_BITS(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .w_addr(w_addr_b), .w_data(w_data_b), .x_addr(x_addr_b), .x_data(x_data_b),
    .b_addr(b_addr_b), .b_data(b_data_b), .y_addr(y_addr_b), .y_data(y_data_b), .y_we(y_we_b)
  );

  // Synchronous read ports: data appears one cycle after the address.
  always @(posedge clk) begin
    w_data_a <= wm_a[w_addr_a];
    x_data_a <= xm_a[x_addr_a];
    b_data_a <= bm_a[b_addr_a];
    w_data_b <= wm_b[w_addr_b];
    x_data_b <= xm_b[x_addr_b];
    b_data_b <= bm_b[b_addr_b];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s @c%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic load_t1();
    for (int k = 0; k < 8; k++) wm_a[k] = 16'h0000;
    wm_a[0] = 16'h0100; wm_a[1] = 16'h0200; wm_a[2] = 16'h0080;
    wm_a[3] = 16'hFF00; wm_a[4] = 16'h0000; wm_a[5] = 16'h0000;
    xm_a[0] = 16'h0100; xm_a[1] = 16'h0080; xm_a[2] = 16'h0200; xm_a[3] = 16'h0000;
    bm_a[0] = 16'h0040; bm_a[1] = 16'h0000;
  endtask

  // One pass on the 3x2 instance; start is re-pulsed in cycles p1/p2 (0 = never).
  task automatic run_a(input logic [15:0] y0, input logic [15:0] y1, input int p1, input int p2);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      start_a = (c == p1) || (c == p2);
      chk("a_busy", c, busy_a, c <= 10);
      chk("a_we",   c, y_we_a, (c == 5) || (c == 10));
      chk("a_done", c, done_a, c == 11);
      if (c == 1) chk("a_waddr", c, w_addr_a, 32'd0);
      if (c == 2) chk("a_waddr", c, w_addr_a, 32'd1);
      if (c == 3) chk("a_xaddr", c, x_addr_a, 32'd2);
      if (c == 6) chk("a_waddr", c, w_addr_a, 32'd3);
      if (c == 6) chk("a_baddr", c, b_addr_a, 32'd1);
      if (c == 8) chk("a_waddr", c, w_addr_a, 32'd5);
      if (c == 5) chk("a_yaddr", c, y_addr_a, 32'd0);
      if (c == 5) chk("a_y0",    c, y_data_a, y0);
      if (c == 7) chk("a_yhold", c, y_data_a, y0);
      if (c == 10) chk("a_yaddr", c, y_addr_a, 32'd1);
      if (c == 10) chk("a_y1",    c, y_data_a, y1);
      tick();
    end
    start_a = 1'b0;
    chk("a_idle_busy", 12, busy_a, 32'd0);
    chk("a_idle_we",   12, y_we_a, 32'd0);
    chk("a_idle_done", 12, done_a, 32'd0);
    chk("a_idle_y",    12, y_data_a, y1);
  endtask

  initial begin
    rst_n = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    load_t1();
    for (int k = 0; k < 4; k++) begin
      wm_b[k] = 16'h0000;
      bm_b[k] = 16'h0000;
    end
    xm_b[0] = 16'h0000;
    xm_b[1] = 16'h0000;
    tick();
    tick();
    rst_n = 1'b0;

    // Reset state
    chk("rst_busy",  0, busy_a, 32'd0);
    chk("rst_done",  0, done_a, 32'd0);
    chk("rst_we",    0, y_we_a, 32'd0);
    chk("rst_waddr", 0, w_addr_a, 32'd0);
    chk("rst_xaddr", 0, x_addr_a, 32'd0);
    chk("rst_baddr", 0, b_addr_a, 32'd0);
    chk("rst_yaddr", 0, y_addr_a, 32'd0);
    chk("rst_y",     0, y_data_a, 32'd0);
    chk("rst_busy_b", 0, busy_b, 32'd0);
    chk("rst_y_b",    0, y_data_b, 32'd0);
    tick();

    // T1 nominal
    run_a(16'h0340, 16'hFF00, 0, 0);

    // T2 saturation, positive then negative
    for (int k = 0; k < 6; k++) wm_a[k] = 16'h7FFF;
    for (int k = 0; k < 3; k++) xm_a[k] = 16'h7FFF;
    bm_a[0] = 16'h7FFF; bm_a[1] = 16'h7FFF;
    run_a(16'h7FFF, 16'h7FFF, 0, 0);
    for (int k = 0; k < 6; k++) wm_a[k] = 16'h8000;
    run_a(16'h8000, 16'h8000, 0, 0);

    // T3 truncation toward -inf
    for (int k = 0; k < 6; k++) wm_a[k] = 16'h0000;
    wm_a[0] = 16'h0001;
    xm_a[0] = 16'hFF80; xm_a[1] = 16'h0000; xm_a[2] = 16'h0000;
    bm_a[0] = 16'h0000; bm_a[1] = 16'h0000;
    run_a(16'hFFFF, 16'h0000, 0, 0);

    // T4 start while busy and together with done is ignored; then a fresh pass
    load_t1();
    run_a(16'h0340, 16'hFF00, 4, 11);
    tick();
    run_a(16'h0340, 16'hFF00, 0, 0);

    // T5 reset mid-pass
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("t5_we5", 5, y_we_a, 32'd1);
    chk("t5_y5",  5, y_data_a, 32'h0340);
    tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("t5_busy7",  7, busy_a, 32'd0);
    chk("t5_y7",     7, y_data_a, 32'd0);
    chk("t5_waddr7", 7, w_addr_a, 32'd0);
    for (int c = 7; c <= 12; c++) begin
      chk("t5_we",   c, y_we_a, 32'd0);
      chk("t5_done", c, done_a, 32'd0);
      chk("t5_busy", c, busy_a, 32'd0);
      tick();
    end
    run_a(16'h0340, 16'hFF00, 0, 0);

    // Reset and start together: reset wins, start is not remembered
    rst_n = 1'b1;
    start_a = 1'b1;
    tick();
    rst_n = 1'b0;
    start_a = 1'b0;
    chk("rs_busy1", 1, busy_a, 32'd0);
    tick();
    chk("rs_busy2", 2, busy_a, 32'd0);

    // T6 IN=1, OUT=4
    wm_b[0] = 16'h0100; wm_b[1] = 16'h0200; wm_b[2] = 16'h0300; wm_b[3] = 16'h0400;
    xm_b[0] = 16'h0100;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      chk("b_busy", c, busy_b, c <= 12);
      chk("b_we",   c, y_we_b, (c % 3 == 0) && (c <= 12));
      chk("b_done", c, done_b, c == 13);
      if (c == 3)  chk("b_y0", c, {y_addr_b, y_data_b}, {2'd0, 16'h0100});
      if (c == 6)  chk("b_y1", c, {y_addr_b, y_data_b}, {2'd1, 16'h0200});
      if (c == 9)  chk("b_y2", c, {y_addr_b, y_data_b}, {2'd2, 16'h0300});
      if (c == 12) chk("b_y3", c, {y_addr_b, y_data_b}, {2'd3, 16'h0400});
      tick();
    end
    chk("b_idle_busy", 14, busy_b, 32'd0);
    chk("b_idle_done", 14, done_b, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
